axi4_slave_write_responder: RTL and testbench

//  Synthesizable AXI4 subordinate for the write path: accepts AW, takes W beats into a byte-addressed

---
 rtl/axi4_globals_pkg.sv | 42 ++++
 rtl/axi4_burst_addr_gen.sv | 37 +++
 rtl/axi4_slave_write_responder.sv | 210 +++++++++++++++++++++
 tb/tb_axi4_slave_write_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 encodings plus the helpers used by the write-path subordinate.
package axi4_globals_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } awburst_e;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } awsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_WAIT = 2'd2,
        WR_RESP = 2'd3
    } wr_state_e;

    localparam int AXI4_4KB_BOUNDARY = 4096;

    function automatic logic axi4_wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus 4KB page-crossing detect.
module axi4_burst_addr_gen
    import axi4_globals_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  awsize_e                  size_i,
    input  logic [7:0]               len_i,
    input  awburst_e                 burst_i,
    input  logic [ADDRESS_WIDTH-1:0] wrap_lower_i,
    output logic [ADDRESS_WIDTH-1:0] next_addr_o,
    output logic                     crosses_4kb_o
);
    localparam int PAGE_BITS = $clog2(AXI4_4KB_BOUNDARY);

    logic [ADDRESS_WIDTH-1:0] bytes;
    logic [ADDRESS_WIDTH-1:0] aligned;
    logic [ADDRESS_WIDTH-1:0] total;
    logic [ADDRESS_WIDTH-1:0] incr;

    always_comb begin
        bytes       = ADDRESS_WIDTH'(1) << size_i;
        aligned     = addr_i & ~(bytes - ADDRESS_WIDTH'(1));
        total       = bytes * (ADDRESS_WIDTH'(len_i) + ADDRESS_WIDTH'(1));
        incr        = addr_i + bytes;
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = aligned + bytes;
            BURST_WRAP: next_addr_o = (incr >= wrap_lower_i + total) ? wrap_lower_i : incr;
            default:    next_addr_o = addr_i;
        endcase
        crosses_4kb_o = (burst_i == BURST_INCR) &&
                        (next_addr_o[ADDRESS_WIDTH-1:PAGE_BITS] != addr_i[ADDRESS_WIDTH-1:PAGE_BITS]);
    end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 write-path subordinate: one burst at a time into a byte-laned local memory, then a B response.
module axi4_slave_write_responder
    import axi4_globals_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 'h0000_0FFF,
    parameter int                       B_WAIT_CYCLES = 0,
    localparam int                      STRB_W        = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [15:0]              awid,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [7:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awburst,
    input  logic                     awlock,
    input  logic [3:0]               awcache,
    input  logic [2:0]               awprot,
    input  logic [3:0]               awqos,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_W-1:0]        wstrb,
    input  logic                     wlast,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [15:0]              bid,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [MEM_ADDR_BITS-1:0] peek_idx,
    output logic [DATA_WIDTH-1:0]    peek_data
);
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int MEM_WORDS = 2 ** MEM_ADDR_BITS;
    localparam int WAIT_W    = (B_WAIT_CYCLES > 1) ? $clog2(B_WAIT_CYCLES) : 1;

    wr_state_e                state_q;
    logic                     awready_q, wready_q, bvalid_q;
    logic [15:0]              bid_q, id_q;
    bresp_e                   bresp_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, wrap_lower_q;
    awsize_e                  size_q;
    logic [7:0]               len_q, beat_cnt_q;
    awburst_e                 burst_q;
    logic [WAIT_W-1:0]        wait_cnt_q;
    logic                     burst_err_q, slverr_q, decerr_q;

    // Exclusive-access and cache/QoS attributes never change how a write is handled.
    logic unused_attr;
    assign unused_attr = ^{awlock, awcache, awprot, awqos};

    logic [ADDRESS_WIDTH-1:0] aw_bytes, aw_total, aw_wrap_lower;
    logic                     aw_burst_err;
    awburst_e                 aw_burst;

    always_comb begin
        aw_burst      = awburst_e'(awburst);
        aw_bytes      = ADDRESS_WIDTH'(1) << awsize;
        aw_total      = aw_bytes * (ADDRESS_WIDTH'(awlen) + ADDRESS_WIDTH'(1));
        // Legal WRAP totals are powers of two, so masking equals (A0/total)*total.
        aw_wrap_lower = awaddr & ~(aw_total - ADDRESS_WIDTH'(1));
        aw_burst_err  = (aw_burst == BURST_RESERVED) ||
                        (awsize > 3'(LANE_BITS)) ||
                        ((aw_burst == BURST_WRAP) &&
                         (!axi4_wrap_len_legal(awlen) ||
                          ((awaddr & (aw_bytes - ADDRESS_WIDTH'(1))) != '0)));
    end

    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic                     crosses_4kb;

    axi4_burst_addr_gen #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_addr_gen (
        .addr_i       (addr_q),
        .size_i       (size_q),
        .len_i        (len_q),
        .burst_i      (burst_q),
        .wrap_lower_i (wrap_lower_q),
        .next_addr_o  (next_addr),
        .crosses_4kb_o(crosses_4kb)
    );

    logic   w_hs, last_beat, beat_decerr, wlast_err, cross_err, mem_we;
    logic   slverr_d, decerr_d;
    bresp_e resp_d;

    always_comb begin
        w_hs        = (state_q == WR_DATA) && wready_q && wvalid;
        last_beat   = (beat_cnt_q == len_q);
        beat_decerr = (addr_q < MIN_ADDRESS) || (addr_q > MAX_ADDRESS);
        wlast_err   = (wlast != last_beat);
        cross_err   = crosses_4kb && !last_beat;
        mem_we      = w_hs && !areset && !burst_err_q && !beat_decerr;
        slverr_d    = slverr_q | (w_hs & (wlast_err | cross_err));
        decerr_d    = decerr_q | (w_hs & beat_decerr);
        resp_d      = decerr_d ? RESP_DECERR : (slverr_d ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= WR_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RESP_OKAY;
            id_q         <= '0;
            addr_q       <= '0;
            wrap_lower_q <= '0;
            size_q       <= SIZE_1B;
            len_q        <= '0;
            burst_q      <= BURST_FIXED;
            beat_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            burst_err_q  <= 1'b0;
            slverr_q     <= 1'b0;
            decerr_q     <= 1'b0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (awready_q && awvalid) begin
                        id_q         <= awid;
                        addr_q       <= awaddr;
                        wrap_lower_q <= aw_wrap_lower;
                        size_q       <= awsize_e'(awsize);
                        len_q        <= awlen;
                        burst_q      <= aw_burst;
                        beat_cnt_q   <= '0;
                        burst_err_q  <= aw_burst_err;
                        slverr_q     <= aw_burst_err;
                        decerr_q     <= 1'b0;
                        awready_q    <= 1'b0;
                        wready_q     <= 1'b1;
                        state_q      <= WR_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        slverr_q   <= slverr_d;
                        decerr_q   <= decerr_d;
                        addr_q     <= next_addr;
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        // The beat count, not wlast, decides where the burst ends.
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            if (B_WAIT_CYCLES == 0) begin
                                bvalid_q <= 1'b1;
                                bid_q    <= id_q;
                                bresp_q  <= resp_d;
                                state_q  <= WR_RESP;
                            end else begin
                                wait_cnt_q <= '0;
                                state_q    <= WR_WAIT;
                            end
                        end
                    end
                end
                WR_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(B_WAIT_CYCLES - 1)) begin
                        bvalid_q <= 1'b1;
                        bid_q    <= id_q;
                        bresp_q  <= resp_d;
                        state_q  <= WR_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= WR_IDLE;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

    logic [MEM_ADDR_BITS-1:0] mem_idx;
    assign mem_idx = addr_q[MEM_ADDR_BITS+LANE_BITS-1:LANE_BITS];

    // One byte-wide array per lane keeps strobe writes a plain single-port write.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];

        always_ff @(posedge aclk) begin
            if (mem_we && wstrb[gi]) begin
                lane_mem[mem_idx] <= wdata[gi*8 +: 8];
            end
        end

        assign peek_data[gi*8 +: 8] = lane_mem[peek_idx];
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed bench for the AXI4 write responder: B responses scoreboarded, memory checked through peek.
module tb_axi4_slave_write_responder;
    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [9:0]  peek_idx;
    logic [31:0] peek_data;

    axi4_slave_write_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_BITS(10),
        .MIN_ADDRESS(32'h0000_0000), .MAX_ADDRESS(32'h0000_0FFF), .B_WAIT_CYCLES(2)
    ) dut (
        .aclk(clk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(1'b0), .awcache(4'h0), .awprot(3'h0), .awqos(4'h0),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .peek_idx(peek_idx), .peek_data(peek_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  resp;
    } b_exp_t;

    b_exp_t sb_q[$];
    int     cmp_cnt = 0;
    int     err_cnt = 0;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek_check(input string tag, input logic [9:0] idx, input logic [31:0] exp);
        peek_idx = idx;
        #1;
        check(tag, peek_data, exp);
    endtask

    task automatic do_aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [1:0] resp, input bit push);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!awready) check("aw_timeout", 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        if (push) sb_q.push_back('{id: id, resp: resp});
        $display("AW id=%h addr=%h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wready) check("w_timeout", 0, 1);
        @(negedge clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
        $display("W  data=%h strb=%h last=%0d", data, strb, last);
    endtask

    // Called at the first falling edge after the last W handshake.
    task automatic wait_b(input int hold);
        int     n;
        b_exp_t e;
        n = 1;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            check("b_timeout", 0, 1);
            return;
        end
        check("b_latency", n, 3);
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("bid", bid, e.id);
        check("bresp", bresp, e.resp);
        repeat (hold) begin
            @(negedge clk);
            check("b_hold_valid", bvalid, 1);
            check("b_hold_id", bid, e.id);
            check("b_hold_resp", bresp, e.resp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 0);
        check("awready_after_b", awready, 1);
        $display("B  id=%h resp=%0d", e.id, e.resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        bit seen_b;
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wdata = '0; wstrb = '0; peek_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        areset = 1'b0;
        @(negedge clk);
        check("awready_after_rst", awready, 1);

        // W without AW is never accepted
        wvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_wready", wready, 0);
        end
        wvalid = 1'b0;

        // INCR, with bready held low for five cycles
        do_aw(16'h1234, 32'h10, 8'd3, 3'd2, INCR, OKAY, 1);
        for (int i = 1; i <= 4; i++) send_w(32'(i), 4'hF, i == 4);
        check("wready_after_last", wready, 0);
        wait_b(5);
        for (int i = 0; i < 4; i++) peek_check("incr_word", 10'(4 + i), 32'(i + 1));

        // WRAP: beats 0x38, 0x3C, 0x30, 0x34
        do_aw(16'h0022, 32'h38, 8'd3, 3'd2, WRAP, OKAY, 1);
        for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), 4'hF, i == 3);
        wait_b(0);
        peek_check("wrap_w14", 10'd14, 32'hA0);
        peek_check("wrap_w15", 10'd15, 32'hA1);
        peek_check("wrap_w12", 10'd12, 32'hA2);
        peek_check("wrap_w13", 10'd13, 32'hA3);

        // FIXED narrow strobes merging into one word
        do_aw(16'h0003, 32'h20, 8'd0, 3'd2, INCR, OKAY, 1);
        send_w(32'h0, 4'hF, 1);
        wait_b(0);
        do_aw(16'h0004, 32'h20, 8'd2, 3'd2, FIXED, OKAY, 1);
        send_w(32'h0000_00AA, 4'h1, 0);
        send_w(32'h0000_BB00, 4'h2, 0);
        send_w(32'h00CC_0000, 4'h4, 1);
        wait_b(0);
        peek_check("fixed_w8", 10'd8, 32'h00CC_BBAA);

        // Out-of-range address: DECERR, aliased word 0 untouched
        do_aw(16'h0005, 32'h0, 8'd0, 3'd2, INCR, OKAY, 1);
        send_w(32'h5555_AAAA, 4'hF, 1);
        wait_b(0);
        do_aw(16'h0006, 32'h1000, 8'd0, 3'd2, INCR, DECERR, 1);
        send_w(32'hFFFF_FFFF, 4'hF, 1);
        wait_b(0);
        peek_check("decerr_w0", 10'd0, 32'h5555_AAAA);

        // INCR running past 4KB into undecoded space: DECERR dominates
        do_aw(16'h0007, 32'hFF8, 8'd3, 3'd2, INCR, DECERR, 1);
        for (int i = 0; i < 4; i++) send_w(32'hC0 + 32'(i), 4'hF, i == 3);
        wait_b(0);
        peek_check("cross_w1022", 10'd1022, 32'hC0);
        peek_check("cross_w1023", 10'd1023, 32'hC1);
        peek_check("cross_w0", 10'd0, 32'h5555_AAAA);

        // Reserved burst: SLVERR and no writes
        do_aw(16'h0008, 32'h40, 8'd1, 3'd2, INCR, OKAY, 1);
        send_w(32'h1111_1111, 4'hF, 0);
        send_w(32'h2222_2222, 4'hF, 1);
        wait_b(0);
        do_aw(16'h0009, 32'h40, 8'd1, 3'd2, RSVD, SLVERR, 1);
        send_w(32'hDEAD_0000, 4'hF, 0);
        send_w(32'hDEAD_0001, 4'hF, 1);
        wait_b(0);
        peek_check("rsvd_w16", 10'd16, 32'h1111_1111);
        peek_check("rsvd_w17", 10'd17, 32'h2222_2222);

        // Early wlast: all four beats still taken, SLVERR
        do_aw(16'h000A, 32'h50, 8'd3, 3'd2, INCR, SLVERR, 1);
        for (int i = 0; i < 4; i++) send_w(32'hE0 + 32'(i), 4'hF, i == 1);
        check("wlast_wready_end", wready, 0);
        wait_b(0);
        for (int i = 0; i < 4; i++) peek_check("wlast_word", 10'(20 + i), 32'hE0 + 32'(i));

        // Reset mid-burst: no B, partial data kept, awready back next cycle
        do_aw(16'h000B, 32'h60, 8'd3, 3'd2, INCR, OKAY, 0);
        send_w(32'h6000_0000, 4'hF, 0);
        send_w(32'h6000_0001, 4'hF, 0);
        areset = 1'b1;
        @(negedge clk);
        check("midrst_wready", wready, 0);
        check("midrst_bvalid", bvalid, 0);
        areset = 1'b0;
        @(negedge clk);
        check("midrst_awready", awready, 1);
        seen_b = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bvalid) seen_b = 1'b1;
        end
        check("midrst_no_b", seen_b, 0);
        peek_check("midrst_w24", 10'd24, 32'h6000_0000);
        peek_check("midrst_w25", 10'd25, 32'h6000_0001);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
